// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Opcodes of the control-transfer instructions resolved in ID.
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] J   = 6'b000010;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch stage and memory.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry buffer holding a word fetched while the pipeline is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clr_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  logic [31:0] instr_q;
  logic [31:0] pc4_q;

  // Clear dominates load so a redirect always drops the buffered word.
  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake and IF/ID register.
// Optional performance counters are enabled with the IF_PERF_CNT_EN macro.
module if_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_write,
  input  logic                IF_ID_write,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  if_fetch_stage_if.master    imem,
  output logic [31:0]         IF_ID_instr,
  output logic [31:0]         IF_ID_pc4,
  output logic                IF_ID_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count,
`endif
  output logic                fetch_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;

  logic         stall, redir_ok, req;
  logic [31:0]  pc_plus4, redir_tgt;
  logic         buf_load, buf_clr;
  logic [31:0]  buf_instr, buf_pc4;

  assign stall     = !pc_write || !IF_ID_write;
  assign redir_ok  = redirect && !stall;
  assign pc_plus4  = pc_q + PC_STEP;
  assign redir_tgt = word_align(redirect_pc);

  // Request stays up through DRAIN so an in-flight transfer is never withdrawn.
  assign req             = rst && (state_q != HOLD);
  assign imem.imem_req   = req;
  assign imem.imem_addr  = pc_q;
  assign fetch_busy      = (state_q == FETCH) && req && !imem.imem_ready;
  assign IF_ID_instr     = instr_q;
  assign IF_ID_pc4       = pc4_q;
  assign IF_ID_valid     = valid_q;

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clr_i   (buf_clr),
    .instr_i (imem.imem_rdata),
    .pc4_i   (pc_plus4),
    .instr_o (buf_instr),
    .pc4_o   (buf_pc4)
  );

  // Next-state, PC and IF/ID update: redirect > stall > advance.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    buf_load = 1'b0;
    buf_clr  = 1'b0;
    if (redir_ok) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
      buf_clr = 1'b1;
    end
    unique case (state_q)
      FETCH: begin
        if (redir_ok) begin
          if (imem.imem_ready) begin
            pc_d = redir_tgt;
          end else begin
            tgt_d   = redir_tgt;
            state_d = DRAIN;
          end
        end else if (imem.imem_ready) begin
          if (!stall) begin
            instr_d = imem.imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir_ok) begin
          pc_d    = redir_tgt;
          state_d = FETCH;
        end else if (!stall) begin
          instr_d = buf_instr;
          pc4_d   = buf_pc4;
          valid_d = 1'b1;
          pc_d    = buf_pc4;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redir_ok) begin
          tgt_d = redir_tgt;
        end
        // Completing the discarded transfer is not an advance, so stall does not gate it.
        if (imem.imem_ready) begin
          pc_d    = redir_ok ? redir_tgt : tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Pipeline state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Free-running wrap-around stall and flush counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redir_ok) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule
